// File: rtl/qs_fifo_flags.sv
// qs_fifo_flags: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds, sticky overflow/underflow flags,
// synchronous flush and selectable first-word-fall-through read mode.
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous active-low reset (0 = reset)
//   push_i         write request
//   push_data_i    write data
//   pop_i          read request
//   flush_i        synchronous flush, empties the FIFO
//   clr_err_i      clears overflow_o / underflow_o
//   pop_data_o     read data (registered or fall-through, see FWFT)
//   full_o         count == DEPTH
//   empty_o        count == 0
//   almost_full_o  count >= AF_THRESH
//   almost_empty_o count <= AE_THRESH
//   count_o        current occupancy 0..DEPTH
//   overflow_o     sticky: push refused because FIFO was full
//   underflow_o    sticky: pop attempted while empty
module qs_fifo_flags #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3,
    parameter int AE_THRESH = 1,
    parameter int FWFT      = 0,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic              clr_err_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [CW-1:0]     count_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    localparam int PW = $clog2(DEPTH);

    // Pointer increment with wrap at DEPTH-1, so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            ptr_inc = {PW{1'b0}};
        end else begin
            ptr_inc = p + PW'(1);
        end
    endfunction

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PW-1:0]     wr_ptr_r;
    logic [PW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;
    logic              overflow_r;
    logic              underflow_r;

    logic empty_s;
    logic full_s;
    logic pop_req_ok_s;
    logic push_req_ok_s;
    logic pop_ok_s;
    logic push_ok_s;
    logic ovf_set_s;
    logic unf_set_s;

    // Status decode and push/pop acceptance; flush suppresses every operation
    // and every error set for its cycle.
    always_comb begin
        empty_s       = (count_r == CW'(0));
        full_s        = (count_r == CW'(DEPTH));
        pop_req_ok_s  = pop_i & ~empty_s;
        // A full FIFO still takes a write when the same cycle's pop frees a slot.
        push_req_ok_s = push_i & (~full_s | pop_req_ok_s);
        pop_ok_s      = pop_req_ok_s & ~flush_i;
        push_ok_s     = push_req_ok_s & ~flush_i;
        ovf_set_s     = push_i & ~push_req_ok_s & ~flush_i;
        unf_set_s     = pop_i & empty_s & ~flush_i;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            if (push_ok_s && !pop_ok_s) begin
                count_r <= count_r + CW'(1);
            end else if (pop_ok_s && !push_ok_s) begin
                count_r <= count_r - CW'(1);
            end
        end
    end

    // Sticky error flags; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= ovf_set_s | (overflow_r & ~clr_err_i);
            underflow_r <= unf_set_s | (underflow_r & ~clr_err_i);
        end
    end

    // Storage array, deliberately not reset. When full with a simultaneous
    // pop, wr_ptr == rd_ptr and the read path samples the old word first.
    always_ff @(posedge clk) begin
        if (reset && push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data_i;
        end
    end

    generate
        if (FWFT == 0) begin : g_reg_rd
            logic [DATA_W-1:0] rd_data_r;

            // Registered read: word is captured on an accepted pop and held.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    rd_data_r <= {DATA_W{1'b0}};
                end else if (pop_ok_s) begin
                    rd_data_r <= mem_r[rd_ptr_r];
                end
            end

            assign pop_data_o = rd_data_r;
        end else begin : g_fwft_rd
            // Fall-through read: head entry shown while not empty, else zero.
            always_comb begin
                if (empty_s) begin
                    pop_data_o = {DATA_W{1'b0}};
                end else begin
                    pop_data_o = mem_r[rd_ptr_r];
                end
            end
        end
    endgenerate

    assign full_o         = full_s;
    assign empty_o        = empty_s;
    assign almost_full_o  = (count_r >= CW'(AF_THRESH));
    assign almost_empty_o = (count_r <= CW'(AE_THRESH));
    assign count_o        = count_r;
    assign overflow_o     = overflow_r;
    assign underflow_o    = underflow_r;

endmodule

// File: doc/qs_fifo_flags.md
Name: qs_fifo_flags

Overview:
Parametrised synchronous FIFO; successor to the two-entry qs_fifo.
- Adds: arbitrary (non-power-of-2) depth, an occupancy count, programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between single-clock producer/consumer stages as the common buffering primitive.

Parameters:
- DATA_W, 8: data width in bits.
- DEPTH, 4: number of entries; legal range >= 2; need not be a power of 2.
- AF_THRESH, 3: almost_full_o asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 1: almost_empty_o asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0:
  - 0 = registered read: data appears the cycle after a pop.
  - 1 = head entry is visible on pop_data_o while not empty.
- CW, $clog2(DEPTH+1): count width (derived; not to be overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- push_i  in  1  write request.
- push_data_i  in  DATA_W  write data.
- pop_i  in  1  read request.
- flush_i  in  1  synchronous flush (empties FIFO).
- clr_err_i  in  1  clears overflow_o/underflow_o.
- pop_data_o  out  DATA_W  read data.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- almost_full_o  out  1  count >= AF_THRESH.
- almost_empty_o  out  1  count <= AE_THRESH.
- count_o  out  CW  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: push attempted while full and not accepted.
- underflow_o  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (reset==0 at posedge):
  - wr_ptr = rd_ptr = count = 0.
  - pop_data_o = 0, overflow_o = underflow_o = 0.
  - Resulting outputs: empty_o = 1, almost_empty_o = 1, full_o = 0, almost_full_o = 0.
  - Memory contents are not cleared.
  - Reset overrides all other inputs, including mid-burst.
- Status outputs are combinational decodes of the registered count; no extra latency.
- Pop acceptance: pop_ok = pop_i & !empty_o.
- Push acceptance: push_ok = push_i & (!full_o | pop_ok). A push into a full FIFO is accepted when a pop is accepted in the same cycle.
- Push into empty with simultaneous pop: pop rejected (underflow_o set), push accepted, count becomes 1.
- Count update:
  - push_ok only: +1.
  - pop_ok only: -1.
  - both: unchanged.
  - Count never exceeds DEPTH and never goes below 0.
- Pointers advance by 1 on an accepted operation and wrap from DEPTH-1 to 0.
- FWFT=0 read path:
  - On pop_ok, pop_data_o <= mem[rd_ptr] at the clock edge; data is valid the following cycle.
  - pop_data_o holds its last value otherwise, including after flush.
- FWFT=1 read path:
  - pop_data_o = mem[rd_ptr] combinationally when !empty_o, else 0.
  - pop_i acknowledges the shown word; the next word appears the cycle after.
  - A word written into an empty FIFO is visible on pop_data_o the cycle after the push edge.
- Errors:
  - overflow_o sets on push_i & !push_ok.
  - underflow_o sets on pop_i & empty_o.
  - Both hold until clr_err_i==1 or reset.
  - A set and a clear in the same cycle: the set wins.
- Flush (flush_i==1):
  - Priority over push/pop; that cycle's push/pop are ignored and no error flags are set.
  - Pointers and count -> 0.
  - Existing error flags and pop_data_o (FWFT=0) are unchanged.
- Write-port collision is impossible: a full FIFO writes at wr_ptr == rd_ptr only when the same slot is being read that cycle, and the read takes the old data (read-before-write).

Test Plan:
- Default params, FWFT=0; push 0xA1, 0xB2, 0xC3, 0xD4 on consecutive cycles:
  - count_o steps 1,2,3,4.
  - almost_empty_o deasserts at count 2.
  - almost_full_o asserts at count 3; full_o asserts at count 4.
  - Then pop four times: pop_data_o shows A1, B2, C3, D4, each one cycle after its pop; empty_o = 1 at end.
- Full FIFO, push 0xEE with pop_i=0 -> overflow_o = 1, count stays 4. Then push 0xEE together with pop_i=1 -> both accepted, count stays 4. Drain -> order B2, C3, D4, EE after refilling from A1..D4. Then clr_err_i=1 for one cycle -> overflow_o = 0.
- Empty FIFO, push 0x55 with pop_i=1 -> underflow_o = 1, count = 1. Next pop returns 0x55.
- Wrap-around with DEPTH=3, AF_THRESH=2: run 10 interleaved push/pop pairs of values 0x01..0x0A -> output sequence is 0x01..0x0A in order, count never exceeds 3.
- FWFT=1: push 0x3C into an empty FIFO -> pop_data_o = 0x3C the next cycle with no pop. Pop -> pop_data_o = 0 and empty_o = 1 the cycle after.
- With count = 3, assert flush_i together with push_i -> count = 0, empty_o = 1, no overflow. Then assert reset=0 mid-burst -> all outputs return to their reset values on the next edge.
